multi_alarm_clock_fsm: RTL and testbench

Parametrised clock/alarm controller for the 7-segment clock design. It keeps 24-hour time and supports NUM_ALARMS independently armed alarms, each with an editable hour and minute. It adds snooze and a ring timeout. It sits between the pushbutton debouncers and the display multiplexer, and runs entirely in the 200 Hz clk_out domain, with a one-cycle 1 Hz enable.

---
 rtl/multi_alarm_clock_fsm.sv | 173 +++++++++++++++++
 tb/tb_multi_alarm_clock_fsm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_clock_fsm.sv
// multi_alarm_clock_fsm: 24-hour clock with NUM_ALARMS editable alarms, snooze and ring timeout
module multi_alarm_clock_fsm #(
    parameter int NUM_ALARMS     = 2,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int TICKS_PER_SEC  = 200
) (
    input  logic                  clk_out,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic                  btn_c,
    input  logic                  btn_l,
    input  logic                  btn_r,
    input  logic                  btn_u,
    input  logic                  btn_d,
    output logic [4:0]            time_hr,
    output logic [5:0]            time_min,
    output logic [5:0]            time_sec,
    output logic [4:0]            disp_hr,
    output logic [5:0]            disp_min,
    output logic [4:0]            field_led,
    output logic [1:0]            sel,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic                  ringing,
    output logic [1:0]            ring_idx,
    output logic                  blink,
    output logic                  sound
);
    localparam int IW   = NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1;
    localparam int HALF = TICKS_PER_SEC / 2;
    localparam int BW   = $clog2(HALF + 1);

    typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, AL_HR, AL_MIN, AL_ARM, RING} state_t;

    state_t                state, state_n;
    logic [4:0]            al_hr [NUM_ALARMS];
    logic [5:0]            al_min [NUM_ALARMS];
    logic [4:0]            snz_hr, hr_n;
    logic [5:0]            snz_min, min_n, sec_n;
    logic [6:0]            snz_sum;
    logic [1:0]            snz_idx, fire_idx;
    logic                  snz_act, tick, fire, last, edit, any_btn, ring_done;
    logic [NUM_ALARMS-1:0] hit;
    logic [7:0]            ring_cnt;
    logic [BW-1:0]         blink_cnt;
    logic [IW-1:0]         si;

    function automatic logic [4:0] step_hr(input logic [4:0] v, input logic up);
        return up ? (v == 5'd23 ? 5'd0 : v + 5'd1) : (v == 5'd0 ? 5'd23 : v - 5'd1);
    endfunction

    function automatic logic [5:0] step_min(input logic [5:0] v, input logic up);
        return up ? (v == 6'd59 ? 6'd0 : v + 6'd1) : (v == 6'd0 ? 6'd59 : v - 6'd1);
    endfunction

    // Ticked time, alarm/snooze match and button qualifiers for this cycle
    always_comb begin
        si        = sel[IW-1:0];
        tick      = sec_tick && state != SET_HR && state != SET_MIN;
        sec_n     = tick ? step_min(time_sec, 1'b1) : time_sec;
        min_n     = tick && time_sec == 6'd59 ? step_min(time_min, 1'b1) : time_min;
        hr_n      = tick && time_sec == 6'd59 && time_min == 6'd59 ? step_hr(time_hr, 1'b1) : time_hr;
        hit       = '0;
        fire_idx  = snz_idx;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            hit[k] = alarm_en[k] && al_hr[k] == hr_n && al_min[k] == min_n;
            if (hit[k]) fire_idx = 2'(k);
        end
        fire      = state == RUN && tick && sec_n == 6'd0 &&
                    (|hit || (snz_act && snz_hr == hr_n && snz_min == min_n));
        last      = sel == 2'(NUM_ALARMS - 1);
        any_btn   = btn_c || btn_l || btn_r || btn_u || btn_d;
        edit      = (btn_u || btn_d) && !btn_c && !btn_l && !btn_r;
        ring_done = sec_tick && {1'b0, ring_cnt} + 9'd1 == 9'(RING_TIMEOUT_S);
        snz_sum   = {1'b0, min_n} + 7'(SNOOZE_MIN);
    end

    // Next state: centre exits edits, right/left walk the field ring, alarms preempt RUN
    always_comb begin
        state_n = state;
        case (state)
            RUN:     state_n = fire ? RING : btn_c ? SET_HR : RUN;
            SET_HR:  state_n = btn_c ? RUN : btn_r ? SET_MIN : btn_l ? AL_ARM : SET_HR;
            SET_MIN: state_n = btn_c ? RUN : btn_r ? AL_HR : btn_l ? SET_HR : SET_MIN;
            AL_HR:   state_n = btn_c ? RUN : btn_r ? AL_MIN : btn_l ? (sel == 2'd0 ? SET_MIN : AL_ARM) : AL_HR;
            AL_MIN:  state_n = btn_c ? RUN : btn_r ? AL_ARM : btn_l ? AL_HR : AL_MIN;
            AL_ARM:  state_n = btn_c ? RUN : btn_r ? (last ? SET_HR : AL_HR) : btn_l ? AL_MIN : AL_ARM;
            RING:    state_n = any_btn || ring_done ? RUN : RING;
            default: state_n = RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) state <= RUN;
        else state <= state_n;
    end

    // Time, alarm settings, selection, snooze and ring bookkeeping
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            time_hr  <= '0;
            time_min <= '0;
            time_sec <= '0;
            sel      <= '0;
            ring_idx <= '0;
            alarm_en <= '0;
            snz_act  <= 1'b0;
            snz_hr   <= '0;
            snz_min  <= '0;
            snz_idx  <= '0;
            ring_cnt <= '0;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                al_hr[k]  <= '0;
                al_min[k] <= '0;
            end
        end else begin
            time_hr  <= hr_n;
            time_min <= min_n;
            time_sec <= sec_n;
            if (edit && state == SET_HR) time_hr <= step_hr(hr_n, btn_u);
            if (edit && state == SET_MIN) begin
                time_min <= step_min(min_n, btn_u);
                time_sec <= '0;
            end
            if (edit && state == AL_HR) al_hr[si] <= step_hr(al_hr[si], btn_u);
            if (edit && state == AL_MIN) al_min[si] <= step_min(al_min[si], btn_u);
            if (edit && state == AL_ARM) alarm_en[si] <= ~alarm_en[si];
            if (state == RUN && btn_c && !fire) begin
                sel     <= '0;
                snz_act <= 1'b0;
            end
            if (state == SET_HR && btn_l && !btn_c && !btn_r) sel <= 2'(NUM_ALARMS - 1);
            if (state == AL_HR && btn_l && !btn_c && !btn_r && sel != 2'd0) sel <= sel - 2'd1;
            if (state == AL_ARM && btn_r && !btn_c) sel <= last ? 2'd0 : sel + 2'd1;
            if (fire) begin
                ring_idx <= fire_idx;
                snz_act  <= 1'b0;
                ring_cnt <= '0;
            end
            if (state == RING && sec_tick) ring_cnt <= ring_cnt + 8'd1;
            if (state == RING && any_btn && !btn_c) begin
                snz_act <= 1'b1;
                snz_idx <= ring_idx;
                snz_min <= snz_sum >= 7'd60 ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
                snz_hr  <= snz_sum >= 7'd60 ? step_hr(hr_n, 1'b1) : hr_n;
            end
        end
    end

    // Free-running half-period counter for the blink square wave, low first after reset
    always_ff @(posedge clk_out or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BW'(HALF - 1)) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + BW'(1);
        end
    end

    assign disp_hr   = state inside {AL_HR, AL_MIN, AL_ARM} ? al_hr[si] : time_hr;
    assign disp_min  = state inside {AL_HR, AL_MIN, AL_ARM} ? al_min[si] : time_min;
    assign field_led = state == SET_HR  ? 5'b00001 :
                       state == SET_MIN ? 5'b00010 :
                       state == AL_HR   ? 5'b00100 :
                       state == AL_MIN  ? 5'b01000 :
                       state == AL_ARM  ? 5'b10000 : 5'b00000;
    assign ringing   = state == RING;
    assign sound     = ringing && blink;
endmodule

// File: tb/tb_multi_alarm_clock_fsm.sv
// tb_multi_alarm_clock_fsm: directed and random stimulus checked against a seconds-of-day reference model
module tb_multi_alarm_clock_fsm;
    localparam int N = 2, SNZ = 5, RTO = 60, TPS = 8, HALF = TPS / 2, P = 2 + 3 * N;
    localparam bit [5:0] BC = 6'b100000, BL = 6'b010000, BR = 6'b001000;
    localparam bit [5:0] BU = 6'b000100, BD = 6'b000010, TK = 6'b000001;

    logic clk_out = 1'b0, reset = 1'b1, sec_tick = 1'b0;
    logic btn_c = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
    logic [4:0] time_hr, disp_hr, field_led;
    logic [5:0] time_min, time_sec, disp_min;
    logic [1:0] sel, ring_idx;
    logic [N-1:0] alarm_en;
    logic ringing, blink, sound;

    multi_alarm_clock_fsm #(.NUM_ALARMS(N), .SNOOZE_MIN(SNZ), .RING_TIMEOUT_S(RTO), .TICKS_PER_SEC(TPS)) dut (
        .clk_out(clk_out), .reset(reset), .sec_tick(sec_tick),
        .btn_c(btn_c), .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
        .time_hr(time_hr), .time_min(time_min), .time_sec(time_sec),
        .disp_hr(disp_hr), .disp_min(disp_min), .field_led(field_led), .sel(sel),
        .alarm_en(alarm_en), .ringing(ringing), .ring_idx(ring_idx), .blink(blink), .sound(sound)
    );

    always #5 clk_out = ~clk_out;

    int total = 0, bad = 0;
    // mode: 0 run, 1 editing page p, 2 ringing; t seconds of day; am minutes of day
    int t, mode, p, sel_m, ri, rc, sz_act, sz_t, sz_idx, edges;
    int am[N];
    bit en[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        t = 0; mode = 0; p = 0; sel_m = 0; ri = 0; rc = 0;
        sz_act = 0; sz_t = 0; sz_idx = 0; edges = 0;
        for (int i = 0; i < N; i++) begin am[i] = 0; en[i] = 0; end
    endtask

    task automatic m_step(input bit c, l, r, u, d, tk);
        int nt, h, m, k, f;
        bit hit;
        edges++;
        nt = (tk && !(mode == 1 && p < 2)) ? (t + 1) % 86400 : t;
        if (mode == 0) begin
            hit = 0;
            k = -1;
            if (tk && nt % 60 == 0) begin
                for (int i = N - 1; i >= 0; i--) if (en[i] && am[i] == nt / 60) k = i;
                hit = k >= 0 || (sz_act != 0 && sz_t == nt / 60);
            end
            if (hit) begin
                mode = 2; ri = k >= 0 ? k : sz_idx; sz_act = 0; rc = 0;
            end else if (c) begin
                mode = 1; p = 0; sel_m = 0; sz_act = 0;
            end
        end else if (mode == 1) begin
            if (c) mode = 0;
            else if (r) p = (p + 1) % P;
            else if (l) p = (p + P - 1) % P;
            else if (u || d) begin
                h = nt / 3600;
                m = (nt / 60) % 60;
                if (p == 0) nt = ((h + (u ? 1 : 23)) % 24) * 3600 + nt % 3600;
                else if (p == 1) nt = h * 3600 + ((m + (u ? 1 : 59)) % 60) * 60;
                else begin
                    k = (p - 2) / 3;
                    f = (p - 2) % 3;
                    if (f == 0) am[k] = ((am[k] / 60 + (u ? 1 : 23)) % 24) * 60 + am[k] % 60;
                    else if (f == 1) am[k] = (am[k] / 60) * 60 + (am[k] % 60 + (u ? 1 : 59)) % 60;
                    else en[k] = !en[k];
                end
            end
            if (mode == 1) sel_m = p >= 2 ? (p - 2) / 3 : 0;
        end else begin
            if (c || l || r || u || d) begin
                mode = 0;
                if (!c) begin sz_act = 1; sz_t = (nt / 60 + SNZ) % 1440; sz_idx = ri; end
            end else if (tk) begin
                rc++;
                if (rc == RTO) mode = 0;
            end
        end
        t = nt;
    endtask

    task automatic check_all();
        int k;
        logic [N-1:0] ev;
        logic b;
        k = (mode == 1 && p >= 2) ? (p - 2) / 3 : 0;
        for (int i = 0; i < N; i++) ev[i] = en[i];
        b = ((edges / HALF) % 2) == 1;
        chk("time", {time_hr, time_min, time_sec}, {5'(t / 3600), 6'((t / 60) % 60), 6'(t % 60)});
        chk("disp", {disp_hr, disp_min}, (mode == 1 && p >= 2) ? {5'(am[k] / 60), 6'(am[k] % 60)}
                                                               : {5'(t / 3600), 6'((t / 60) % 60)});
        chk("field_led", field_led, mode == 1 ? (p < 2 ? 1 << p : 1 << (2 + (p - 2) % 3)) : 0);
        chk("sel", sel, sel_m);
        chk("alarm_en", alarm_en, ev);
        chk("ring", {ringing, ring_idx}, {mode == 2, 2'(ri)});
        chk("blink_sound", {blink, sound}, {b, b && mode == 2});
    endtask

    task automatic cyc(input bit [5:0] b);
        {btn_c, btn_l, btn_r, btn_u, btn_d, sec_tick} = b;
        @(posedge clk_out);
        #1;
        m_step(b[5], b[4], b[3], b[2], b[1], b[0]);
        check_all();
    endtask

    task automatic rep(input bit [5:0] b, input int n);
        repeat (n) cyc(b);
    endtask

    task automatic do_reset();
        {btn_c, btn_l, btn_r, btn_u, btn_d, sec_tick} = 6'b0;
        reset = 1'b1;
        #1;
        m_reset();
        check_all();
        @(negedge clk_out);
        reset = 1'b0;
    endtask

    initial begin
        bit [5:0] b;
        @(posedge clk_out);
        #1;
        m_reset();
        check_all();
        @(negedge clk_out);
        reset = 1'b0;
        rep(TK, 3);
        cyc(BC);
        rep(BU, 25);
        chk("hr_after_25_up", time_hr, 1);
        cyc(BR);
        cyc(BD);
        rep(TK, 3);
        chk("min_wrap_down", time_min, 59);
        chk("sec_frozen_in_edit", time_sec, 0);
        rep(BR, 4);
        rep(BU, 6);
        cyc(BR);
        rep(BD, 30);
        cyc(BR);
        cyc(BU);
        cyc(BR);
        chk("sel_wrapped", sel, 0);
        rep(BU, 5);
        cyc(BR);
        rep(BD, 30);
        cyc(BC);
        rep(TK, 58);
        chk("no_ring_early", ringing, 0);
        rep(TK, 2);
        chk("ring_alarm1", {ringing, ring_idx}, 3'b101);
        rep(6'b0, 12);
        rep(TK, 5);
        cyc(BU);
        chk("snoozed", ringing, 0);
        rep(TK, 294);
        chk("snooze_not_yet", ringing, 0);
        cyc(TK);
        chk("snooze_ring", {ringing, ring_idx}, 3'b101);
        rep(TK, 59);
        chk("still_ringing", ringing, 1);
        cyc(TK);
        chk("timeout_dismiss", ringing, 0);
        rep(TK, 60);
        chk("no_rering", ringing, 0);
        cyc(BC);
        rep(BR, 2);
        rep(BU, 12);
        rep(BR, 2);
        cyc(BU);
        cyc(BR);
        rep(BU, 6);
        cyc(BR);
        rep(BU, 30);
        rep(BR, 2);
        rep(BU, 5);
        cyc(BR);
        rep(BU, 22);
        cyc(BC);
        rep(TK, 60);
        chk("both_ring_lowest", {ringing, ring_idx}, 3'b100);
        rep(6'b0, 3);
        do_reset();
        chk("reset_mid_ring", {ringing, time_hr, time_min, time_sec}, 0);
        cyc(BC);
        cyc(BD);
        cyc(BR);
        cyc(BD);
        cyc(BC);
        rep(TK, 59);
        chk("pre_midnight", {time_hr, time_min, time_sec}, {5'd23, 6'd59, 6'd59});
        cyc(TK);
        chk("midnight_wrap", {time_hr, time_min, time_sec}, 0);
        cyc(BC);
        rep(BR, 3);
        cyc(BU);
        cyc(BR);
        cyc(BU);
        rep(BR, 2);
        rep(BU, 3);
        cyc(BR);
        cyc(BU);
        cyc(BC);
        for (int i = 0; i < 4000; i++) begin
            b = '0;
            if ($urandom_range(15) == 0) b[5 - $urandom_range(4)] = 1'b1;
            if ($urandom_range(63) == 0) b[5:1] = 5'($urandom);
            b[0] = 1'($urandom_range(1));
            if ($urandom_range(1999) == 0) do_reset();
            else cyc(b);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
